// File: rtl/data_mem_responder.sv
// Single-request data-memory responder for the load/store path: holds each request
// for LATENCY cycles, then returns one response strobe with extended load data or an error.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              rsp_valid,
    output logic [31:0]       rdata,
    output logic              rsp_err
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] BYTES    = (ADDR_W+1)'(DEPTH * 4);
    localparam logic [3:0]      CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              l_rd, l_wr;
    logic [2:0]        l_f3;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;

    logic [31:0] mem [DEPTH];

    // In IDLE the live request feeds the checks (needed when LATENCY==1);
    // afterwards the latched copy does, so WAIT/RESP are immune to input changes.
    logic              s_rd, s_wr;
    logic [2:0]        s_f3;
    logic [ADDR_W-1:0] s_addr;
    logic [31:0]       s_wdata;
    logic [IDX_W-1:0]  s_idx;
    logic [1:0]        s_lane;
    logic [31:0]       word, shifted, load_c, rdata_c;
    logic [31:0]       wr_word;
    logic [3:0]        wr_be;
    logic              f3_ok, misal, oor, err_c;

    assign s_rd    = (state == IDLE) ? MemRead  : l_rd;
    assign s_wr    = (state == IDLE) ? MemWrite : l_wr;
    assign s_f3    = (state == IDLE) ? funct3   : l_f3;
    assign s_addr  = (state == IDLE) ? addr     : l_addr;
    assign s_wdata = (state == IDLE) ? wdata    : l_wdata;
    assign s_idx   = s_addr[IDX_W+1:2];
    assign s_lane  = s_addr[1:0];
    assign word    = mem[s_idx];
    assign shifted = word >> {s_lane, 3'b000};

    always_comb begin
        f3_ok = 1'b0;
        if (s_wr && !s_rd) begin
            f3_ok = (s_f3 == 3'b000) || (s_f3 == 3'b001) || (s_f3 == 3'b010);
        end else if (s_rd && !s_wr) begin
            f3_ok = (s_f3 == 3'b000) || (s_f3 == 3'b001) || (s_f3 == 3'b010) ||
                    (s_f3 == 3'b100) || (s_f3 == 3'b101);
        end
        misal = ((s_f3[1:0] == 2'b01) && s_lane[0]) ||
                ((s_f3[1:0] == 2'b10) && (s_lane != 2'b00));
        oor   = {1'b0, s_addr} >= BYTES;
        err_c = (s_rd && s_wr) || !f3_ok || misal || oor;
    end

    always_comb begin
        load_c = shifted;
        case (s_f3)
            3'b000:  load_c = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_c = {24'd0, shifted[7:0]};
            3'b001:  load_c = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_c = {16'd0, shifted[15:0]};
            default: load_c = shifted;
        endcase
        rdata_c = (s_rd && !err_c) ? load_c : 32'd0;
    end

    always_comb begin
        wr_be   = 4'hf;
        wr_word = s_wdata;
        case (s_f3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << s_lane;
                wr_word = {4{s_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = 4'b0011 << {s_lane[1], 1'b0};
                wr_word = {2{s_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'hf;
                wr_word = s_wdata;
            end
        endcase
    end

    // Memory is never cleared; a store lands at the end of its RESP cycle.
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && l_wr && !err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[s_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rdata     <= 32'd0;
            rsp_err   <= 1'b0;
            l_rd      <= 1'b0;
            l_wr      <= 1'b0;
            l_f3      <= 3'd0;
            l_addr    <= '0;
            l_wdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid && (MemRead || MemWrite)) begin
                        l_rd    <= MemRead;
                        l_wr    <= MemWrite;
                        l_f3    <= funct3;
                        l_addr  <= addr;
                        l_wdata <= wdata;
                        if (LATENCY <= 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rdata     <= rdata_c;
                            rsp_err   <= err_c;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rdata     <= rdata_c;
                        rsp_err   <= err_c;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rdata     <= 32'd0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign req_ready = ~busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of load/store vectors plus
// hand-written sequences for continuous requests and reset during WAIT.
module tb_data_mem_responder;

    localparam int DEPTH   = 256;
    localparam int ADDR_W  = 32;
    localparam int LATENCY = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              MemRead, MemWrite;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy, rsp_valid, rsp_err;
    logic [31:0]       rdata;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3), .addr(addr),
        .wdata(wdata), .busy(busy), .rsp_valid(rsp_valid), .rdata(rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a, wd, exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Drives one request, then waits (bounded) for its response and checks it.
    task automatic txn(input string name, input vec_t v);
        int n;
        @(negedge clk);
        chk({name, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; MemRead = v.rd; MemWrite = v.wr;
        funct3 = v.f3; addr = v.a; wdata = v.wd;
        @(negedge clk);
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, ".latency"}, n, LATENCY);
        chk({name, ".rdata"}, rdata, v.exp_rdata);
        chk({name, ".err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
        @(negedge clk);
        chk({name, ".single_pulse"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = 3'd0; addr = '0; wdata = 32'd0;

        vecs[0]  = mk(0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0); // sw
        vecs[1]  = mk(1, 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0); // lw
        vecs[2]  = mk(1, 0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 0); // lb
        vecs[3]  = mk(1, 0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 0); // lbu
        vecs[4]  = mk(1, 0, 3'b001, 32'h10,  32'h0,        32'hFFFFBEEF, 0); // lh
        vecs[5]  = mk(1, 0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 0); // lhu
        vecs[6]  = mk(0, 1, 3'b000, 32'h11,  32'h55,       32'h0,        0); // sb lane 1
        vecs[7]  = mk(1, 0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 0);
        vecs[8]  = mk(1, 0, 3'b010, 32'h12,  32'h0,        32'h0,        1); // misaligned lw
        vecs[9]  = mk(0, 1, 3'b001, 32'h13,  32'hFFFF,     32'h0,        1); // misaligned sh
        vecs[10] = mk(1, 0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 0); // unchanged
        vecs[11] = mk(1, 0, 3'b010, 32'h400, 32'h0,        32'h0,        1); // out of range
        vecs[12] = mk(1, 0, 3'b000, 32'h11,  32'h0,        32'h00000055, 0); // lb positive
        vecs[13] = mk(0, 1, 3'b010, 32'h3FC, 32'h12345678, 32'h0,        0); // last word
        vecs[14] = mk(1, 0, 3'b010, 32'h3FC, 32'h0,        32'h12345678, 0);
        vecs[15] = mk(1, 0, 3'b101, 32'h3FE, 32'h0,        32'h00001234, 0);
        vecs[16] = mk(1, 0, 3'b011, 32'h10,  32'h0,        32'h0,        1); // illegal load f3
        vecs[17] = mk(0, 1, 3'b100, 32'h10,  32'h0,        32'h0,        1); // illegal store f3
        vecs[18] = mk(1, 1, 3'b010, 32'h10,  32'h0,        32'h0,        1); // both strobes
        vecs[19] = mk(0, 1, 3'b001, 32'h12,  32'hCAFE,     32'h0,        0); // sh upper half
        vecs[20] = mk(1, 0, 3'b010, 32'h10,  32'h0,        32'hCAFE55EF, 0);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset.rdata",     rdata,              32'd0);
        chk("reset.rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("reset.busy",      {31'd0, busy},      32'd0);
        chk("reset.req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 21; i++) txn($sformatf("vec%0d", i), vecs[i]);

        // Accept with neither strobe is a no-op.
        @(negedge clk);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("noop.busy", {31'd0, busy}, 32'd0);
        chk("noop.rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Continuous req_valid: accepts every LATENCY+1 cycles, one pulse each.
        @(negedge clk);
        req_valid = 1'b1; MemRead = 1'b1; funct3 = 3'b010; addr = 32'h10;
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("stream%0d.ready", c), {31'd0, req_ready}, {31'd0, (c % 3) == 0});
            chk($sformatf("stream%0d.busy", c),  {31'd0, busy},      {31'd0, (c % 3) != 0});
            chk($sformatf("stream%0d.rsp", c),   {31'd0, rsp_valid}, {31'd0, (c % 3) == 2});
            if (c == 6) begin
                @(negedge clk);
                req_valid = 1'b0; MemRead = 1'b0;
            end else if (c < 8) begin
                @(negedge clk);
            end
            if (c == 6) begin
                // cycle 7 already reached; check it here and skip the loop's own step
                chk("stream7.busy", {31'd0, busy}, 32'd1);
                chk("stream7.rsp", {31'd0, rsp_valid}, 32'd0);
                @(negedge clk);
                chk("stream8.rsp", {31'd0, rsp_valid}, 32'd1);
                chk("stream8.rdata", rdata, 32'hCAFE55EF);
                break;
            end
        end
        @(negedge clk);
        chk("stream.drain_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("stream.drain_ready", {31'd0, req_ready}, 32'd1);

        // Reset in WAIT aborts the store: no pulse, no write.
        @(negedge clk);
        req_valid = 1'b1; MemWrite = 1'b1; funct3 = 3'b010; addr = 32'h10; wdata = 32'h11111111;
        @(negedge clk);
        req_valid = 1'b0; MemWrite = 1'b0;
        chk("abort.busy_in_wait", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.rsp_during_reset", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("abort.no_rsp%0d", c), {31'd0, rsp_valid}, 32'd0);
        end
        chk("abort.ready", {31'd0, req_ready}, 32'd1);
        txn("abort.readback", mk(1, 0, 3'b010, 32'h10, 32'h0, 32'hCAFE55EF, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
